// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared fetch-sequencer state encoding and reset constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_U  = 3'd1,
    LD_U  = 3'd2,
    RD_L  = 3'd3,
    LD_L  = 3'd4,
    VALID = 3'd5
  } fetch_state_t;

  localparam int unsigned PC_RESET = 0;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : Program counter with load (priority) and modulo increment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_reg
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                inc,
  input  logic [PC_WIDTH-1:0] d,
  output logic [PC_WIDTH-1:0] q
);

  logic [PC_WIDTH-1:0] r_pc;

  // Increment wraps naturally at 2^PC_WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= PC_WIDTH'(PC_RESET);
    end else if (load) begin
      r_pc <= d;
    end else if (inc) begin
      r_pc <= r_pc + PC_WIDTH'(1);
    end
  end

  assign q = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module : fetch_ctrl
// Brief  : Two-byte instruction fetch sequencer with valid/ack handoff.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_req,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                mem_ready,
  input  logic                ir_ack,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                mem_rd,
  output logic                LOAD_IRU,
  output logic                LOAD_IRL,
  output logic                ir_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic         w_pc_load;
  logic         w_pc_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A jump in IDLE defers the fetch one cycle so it starts from the new PC.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!pc_load && fetch_req) w_next = RD_U;
      RD_U:    if (mem_ready) w_next = LD_U;
      LD_U:    w_next = RD_L;
      RD_L:    if (mem_ready) w_next = LD_L;
      LD_L:    w_next = VALID;
      VALID:   if (ir_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = (r_state == RD_U) || (r_state == RD_L);
    LOAD_IRU  = (r_state == LD_U);
    LOAD_IRL  = (r_state == LD_L);
    ir_valid  = (r_state == VALID);
    busy      = (r_state != IDLE) && (r_state != VALID);
    w_pc_load = pc_load && ((r_state == IDLE) || (r_state == VALID));
    w_pc_inc  = (r_state == LD_U) || (r_state == LD_L);
  end

  pc_reg #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (w_pc_load),
    .inc   (w_pc_inc),
    .d     (pc_in),
    .q     (pc)
  );

  assign mem_addr = pc;

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the 16-bit instruction register. It owns the program counter, and on each fetch request it reads two consecutive bytes from memory through the MDR. It pulses `LOAD_IRU` for the first byte and `LOAD_IRL` for the second, then presents the completed instruction to the execute stage with a valid/ack handshake. It sits between the memory interface, the `ir` block and the execute controller.

## Interface
Parameters:
- `PC_WIDTH`, default 8: program counter and memory address width.

Ports:
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `fetch_req`  in  1: execute stage requests the next instruction; sampled in IDLE only.
- `pc_load`  in  1: load `pc_in` into PC (jump/branch).
- `pc_in`  in  PC_WIDTH: jump target.
- `mem_ready`  in  1: memory read complete; MDR valid on the following cycle.
- `ir_ack`  in  1: execute stage has consumed IRU/IRL.
- `mem_addr`  out  PC_WIDTH: read address, equal to the current PC.
- `mem_rd`  out  1: memory read strobe.
- `LOAD_IRU`  out  1: one-cycle load strobe to the `ir` upper byte.
- `LOAD_IRL`  out  1: one-cycle load strobe to the `ir` lower byte.
- `ir_valid`  out  1: IRU/IRL hold a complete instruction.
- `pc`  out  PC_WIDTH: current program counter.
- `busy`  out  1: a fetch is in progress (any state except IDLE and VALID).

## Operation
States:
- **IDLE**: all strobes low. If `fetch_req` is high, go to RD_U.
- **RD_U**: `mem_rd`=1, `mem_addr`=PC. Stay while `mem_ready`=0. When `mem_ready`=1, go to LD_U.
- **LD_U**: `LOAD_IRU`=1 for exactly one cycle; PC <= PC+1; go to RD_L.
- **RD_L**: same as RD_U, using the incremented PC. When `mem_ready`=1, go to LD_L.
- **LD_L**: `LOAD_IRL`=1 for exactly one cycle; PC <= PC+1; go to VALID.
- **VALID**: `ir_valid`=1. Stay until `ir_ack`=1, then go to IDLE.

Rules:
- `mem_addr` always equals `pc`.
- `mem_rd` is high only in RD_U and RD_L.
- PC increment is modulo 2^PC_WIDTH: 0xFF + 1 wraps to 0x00 for the default width, with no flag.
- `pc_load` is honoured only in IDLE and VALID. In every other state it is ignored (not queued), so a fetch is never split across two addresses.
- `pc_load` and `fetch_req` high together in IDLE: PC takes `pc_in`, the state stays IDLE, and the fetch begins the next cycle from the new PC. `fetch_req` is level-sensitive, so a request still held is honoured then.
- `pc_load` and `ir_ack` high together in VALID: both take effect; go to IDLE with the new PC.
- `ir_ack` outside VALID is ignored.
- `mem_ready` outside RD_U/RD_L is ignored.
- Reset asserted mid-fetch aborts the fetch immediately. Any partially loaded IR contents are not marked valid.

Reset values: state=IDLE, `pc`=0. `mem_rd`, `LOAD_IRU`, `LOAD_IRL`, `ir_valid` and `busy` are all 0.

## Timing
- All outputs are registered-state decodes (Moore); none depends combinationally on inputs.
- Zero-wait memory (`mem_ready` high in the first read cycle): `fetch_req` sampled at edge 0 gives RD_U at cycle 1, LD_U at 2, RD_L at 3, LD_L at 4. `ir_valid` rises at cycle 5.
- Each wait cycle (`mem_ready`=0) in RD_U or RD_L adds one cycle.
- `LOAD_IRU`/`LOAD_IRL` fall in the cycle after the MDR data becomes valid, so `ir` captures on the edge ending LD_U/LD_L.
- `pc` shows the increment one cycle after LD_U and one cycle after LD_L.
- After `ir_ack`, IDLE lasts at least one cycle before the next fetch. Back-to-back fetch throughput is 6 cycles with zero-wait memory.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum: IDLE, RD_U, LD_U, RD_L, LD_L, VALID.
  - Constant `PC_RESET` = 0.
- Sub-module `pc_reg`: holds the PC and implements load, increment and reset. Load has priority over increment.
- `fetch_ctrl` contains only the FSM and output decode.
- The top-level board wrapper connects `LOAD_IRU`/`LOAD_IRL` to `ir` and MDR to memory data.

## Test plan
- Reset, zero-wait memory, `fetch_req` pulsed: `mem_addr` 0x00 then 0x01; `LOAD_IRU` high at cycle 2, `LOAD_IRL` high at cycle 4; `ir_valid` at cycle 5; `pc`=0x02.
- `mem_ready` held low 3 cycles in RD_U: `mem_rd` stays high with `mem_addr` stable at 0x00; `ir_valid` arrives at cycle 8; no early `LOAD_IRU`.
- `pc_load` with `pc_in`=0xFF in IDLE, then a fetch: reads 0xFF then 0x00; final `pc`=0x01, showing wrap.
- `pc_load` with `pc_in`=0x40 during RD_L: ignored; the fetch completes from the original addresses. The same `pc_load` applied in VALID together with `ir_ack`: IDLE with `pc`=0x40.
- `ir_valid` held without `ir_ack` for 10 cycles: stays in VALID, no strobes, `fetch_req` ignored. Then `ir_ack`: IDLE the next cycle.
- Reset asserted asynchronously during LD_L: all outputs 0 and `pc`=0 without waiting for a clock edge; the FSM stays in IDLE after release.
